// File: rtl/mul_scheduler.sv
// Round-robin issue scheduler for a shared fixed-latency multiply datapath.
// Tracks issues with a tag pipeline and buffers results in a credit-protected FWFT FIFO.
module mul_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 561,
   parameter int RES_W       = 1584,
   parameter int MUL_LATENCY = 2,
   parameter int OUT_DEPTH   = 4,
   parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic                        mul_valid,
   output logic [DATA_W-1:0]           mul_a,
   output logic [DATA_W-1:0]           mul_b,
   input  logic [RES_W-1:0]            mul_res,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [ID_W-1:0]             resp_id,
   output logic [RES_W-1:0]            resp_data,
   output logic                        busy
);
   localparam int INF_W = $clog2(MUL_LATENCY + 1);
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   // Handshakes: a beat moves when valid & ready are both high at a rising edge;
   // valid never waits on ready, and req_ready never depends on resp_ready.
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              grant;
   logic [ID_W-1:0]   grant_id;
   logic              credit;
   int                arb_idx;

   logic [MUL_LATENCY-1:0] tag_v_q;
   logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
   logic                   push;
   logic                   pop;

   logic [INF_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [RES_W-1:0]  data_mem [OUT_DEPTH];
   logic [ID_W-1:0]   id_mem [OUT_DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts every result already committed to a FIFO slot, queued or in flight.
   always_comb begin
      grant     = 1'b0;
      grant_id  = '0;
      arb_idx   = 0;
      req_ready = '0;
      credit    = (int'(inflight_q) + int'(cnt_q)) < OUT_DEPTH;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_idx = int'(ptr_q) + k;
         if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
         if (!grant && credit && req_valid[ID_W'(arb_idx)]) begin
            grant    = 1'b1;
            grant_id = ID_W'(arb_idx);
         end
      end
      if (grant) req_ready[grant_id] = 1'b1;
      ptr_d = ptr_q;
      if (grant) ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
   end

   assign mul_valid = grant;
   assign mul_a     = req_a[int'(grant_id)*DATA_W +: DATA_W];
   assign mul_b     = req_b[int'(grant_id)*DATA_W +: DATA_W];

   assign push = tag_v_q[MUL_LATENCY-1];
   assign pop  = resp_valid & resp_ready;

   always_comb begin
      inflight_d = inflight_q;
      if (grant && !push) inflight_d = inflight_q + 1'b1;
      else if (!grant && push) inflight_d = inflight_q - 1'b1;
      cnt_d = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         tag_v_q    <= '0;
         inflight_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         ptr_q      <= ptr_d;
         tag_v_q[0] <= grant;
         for (int k = 1; k < MUL_LATENCY; k++) tag_v_q[k] <= tag_v_q[k-1];
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Ids and payload need no reset: only the valid bits and counters qualify them.
   always_ff @(posedge clk) begin
      tag_id_q[0] <= grant_id;
      for (int k = 1; k < MUL_LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
      if (push) begin
         data_mem[wr_ptr_q] <= mul_res;
         id_mem[wr_ptr_q]   <= tag_id_q[MUL_LATENCY-1];
      end
   end

   assign resp_valid = (cnt_q != '0);
   assign resp_id    = id_mem[rd_ptr_q];
   assign resp_data  = data_mem[rd_ptr_q];
   assign busy       = (inflight_q != '0) | (cnt_q != '0);
endmodule
